ifmap_rd_addr_gen: RTL and testbench
====================================

IFMAP_RD_ADDR_GEN -- requirements
Module: ifmap_rd_addr_gen

Interface
REQ-001 Parameter MAX_OUT, default 4: maximum read requests outstanding without a returned data packet; legal range 1-15.
REQ-002 Parameter ADDR_W, default 15: read-address width, equal to the ifmap memory's read-address format.
REQ-003 clk  input  1  single clock; all state updates on the rising edge.
REQ-004 rst_n  input  1  reset, asynchronous assert, active-low.
REQ-005 cmd_valid  input  1  layer command present.
REQ-006 cmd_ready  output  1  command accepted when cmd_valid and cmd_ready are both high on a rising edge.
REQ-007 cmd_conv_size  input  6  output-map dimension N; positions run 0..N-1 in each axis.
REQ-008 cmd_fil_size  input  2  filter code: 00=3x3, 01=4x4, 10=5x5, 11=illegal.
REQ-009 addr_valid  output  1  read address valid.
REQ-010 addr_ready  input  1  memory accepts the address when addr_valid and addr_ready are both high.
REQ-011 addr  output  ADDR_W  read address: [14:13] fil_size, [12:7] x, [6:1] y, [0] timestep.
REQ-012 rdata_ret  input  1  one-cycle pulse per read-data packet returned by memory.
REQ-013 busy  output  1  high in every state except IDLE.
REQ-014 done  output  1  one-cycle pulse when a layer completes.
REQ-015 err  output  1  one-cycle pulse when an illegal command is received.

Function
REQ-016 FSM states: IDLE, ISSUE, DRAIN, DONE.
REQ-017 cmd_ready is high only in IDLE.
REQ-018 On command acceptance, N and the filter code are latched, x/y/t counters are cleared, and the state goes to ISSUE.
REQ-019 A command with code 11 is accepted but issues no addresses; err pulses on the next cycle and the state stays in IDLE.
REQ-020 A command with N=0 goes straight to DONE and issues no addresses.
REQ-021 Issue order: t innermost (0 then 1), then y, then x outermost; 2*N*N addresses total.
REQ-022 addr is driven directly from registers; addr_valid is high in ISSUE only while outstanding < MAX_OUT.
REQ-023 addr and addr_valid stay stable while addr_valid is high and addr_ready is low.
REQ-024 On each accepted address: t toggles; on t wrap, y increments; on y = N-1 wrap, y clears and x increments.
REQ-025 Acceptance of the address (x=N-1, y=N-1, t=1) moves the state to DRAIN.
REQ-026 Outstanding counter (4 bits): +1 on address accept, -1 on rdata_ret.
REQ-027 When an accept and rdata_ret fall in the same cycle, the outstanding counter is unchanged.
REQ-028 rdata_ret while the counter is 0 is ignored; the counter saturates at 0.
REQ-029 DRAIN moves to DONE in the cycle the counter reads 0.
REQ-030 In DONE, done is high for exactly one cycle, then the state returns to IDLE.
REQ-031 Back-to-back layers are allowed: a new command may be accepted on the cycle after done.
REQ-032 Issue throughput is one address per cycle when addr_ready is held high and credits are available.

Reset
REQ-033 While rst_n is low: state=IDLE, counters=0, latched N and filter code=0, addr=0, addr_valid=0, busy=0, done=0, err=0.
REQ-034 cmd_ready is 1 from the first rising edge after rst_n deasserts.
REQ-035 Reset asserted mid-layer abandons the layer immediately; no done pulse is produced.
REQ-036 After a mid-layer reset, rdata_ret pulses for the abandoned layer fall under REQ-028 and are ignored.

Structure
REQ-037 Package ifmap_pkg holds the FSM state enum, the filter-code constants (FIL3=00, FIL4=01, FIL5=10), and the address field bit positions.
REQ-038 One sub-module: ifmap_credit_cnt, implementing the outstanding counter with saturation and a can_issue output.

Verification
REQ-039 Command N=2, code 00, addr_ready=1, rdata_ret returned 2 cycles after each accept -> 8 addresses in order (x,y,t) = (0,0,0),(0,0,1),(0,1,0),(0,1,1),(1,0,0)...(1,1,1), each with [14:13]=00, followed by exactly one done pulse.
REQ-040 MAX_OUT=4, N=3, no rdata_ret -> exactly 4 addresses accepted, addr_valid then low; one rdata_ret pulse -> exactly one more address issued.
REQ-041 addr_ready held low for 5 cycles during ISSUE -> addr and addr_valid constant across all 5 cycles, with no skipped or duplicated address.
REQ-042 Command code 11 -> err pulse, no addr_valid, cmd_ready high on the following cycle; command N=0, code 01 -> done pulse, no addresses.
REQ-043 rst_n driven low after 3 of 18 addresses (N=3) -> all outputs at reset values asynchronously; a fresh command then produces a complete, correct 18-address sequence.
REQ-044 Address accept and rdata_ret in the same cycle, and rdata_ret with the counter at 0 -> counter unchanged in both cases; checked by assertion.

Source files
------------

// File: rtl/ifmap_pkg.sv
// Shared types and constants for the ifmap read-address generator:
// FSM states, filter codes and the read-address field layout.
package ifmap_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ISSUE = 2'd1,
      DRAIN = 2'd2,
      DONE  = 2'd3
   } state_t;

   localparam logic [1:0] FIL3    = 2'b00;
   localparam logic [1:0] FIL4    = 2'b01;
   localparam logic [1:0] FIL5    = 2'b10;
   localparam logic [1:0] FIL_BAD = 2'b11;

   localparam int ADDR_T_BIT   = 0;
   localparam int ADDR_Y_LSB   = 1;
   localparam int ADDR_X_LSB   = 7;
   localparam int ADDR_FIL_LSB = 13;
   localparam int ADDR_FIELD_W = 15;

   function automatic logic [ADDR_FIELD_W-1:0] pack_addr(input logic [1:0] fil,
                                                         input logic [5:0] x,
                                                         input logic [5:0] y,
                                                         input logic       t);
      logic [ADDR_FIELD_W-1:0] a;
      a = '0;
      a[ADDR_FIL_LSB +: 2] = fil;
      a[ADDR_X_LSB +: 6]   = x;
      a[ADDR_Y_LSB +: 6]   = y;
      a[ADDR_T_BIT]        = t;
      return a;
   endfunction

endpackage

// File: rtl/ifmap_credit_cnt.sv
// Outstanding-read credit counter: counts accepted addresses not yet
// answered by a returned data packet, floored at zero.
module ifmap_credit_cnt #(
   parameter int MAX_OUT = 4
) (
   input  logic clk,
   input  logic rst_n,
   input  logic inc,
   input  logic dec,
   output logic can_issue,
   output logic is_zero
);

   logic [3:0] cnt_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_q <= 4'd0;
      end else if (inc && !dec) begin
         cnt_q <= cnt_q + 4'd1;
      end else if (dec && !inc && (cnt_q != 4'd0)) begin
         cnt_q <= cnt_q - 4'd1;
      end
   end

   assign can_issue = (cnt_q < 4'(MAX_OUT));
   assign is_zero   = (cnt_q == 4'd0);

   // A simultaneous accept and return nets out; a stray return at zero is dropped.
   a_same_cycle : assert property (@(posedge clk) disable iff (!rst_n)
      (inc && dec) |=> (cnt_q == $past(cnt_q)));
   a_floor_zero : assert property (@(posedge clk) disable iff (!rst_n)
      (dec && !inc && (cnt_q == 4'd0)) |=> (cnt_q == 4'd0));

endmodule

// File: rtl/ifmap_rd_addr_gen.sv
// Walks the (x, y, t) read-address space of one ifmap layer, t innermost,
// throttled by an outstanding-read credit limit.
module ifmap_rd_addr_gen
   import ifmap_pkg::*;
#(
   parameter int MAX_OUT = 4,
   parameter int ADDR_W  = 15
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              cmd_valid,
   output logic              cmd_ready,
   input  logic [5:0]        cmd_conv_size,
   input  logic [1:0]        cmd_fil_size,
   output logic              addr_valid,
   input  logic              addr_ready,
   output logic [ADDR_W-1:0] addr,
   input  logic              rdata_ret,
   output logic              busy,
   output logic              done,
   output logic              err
);

   state_t     state_q, state_d;
   logic [5:0] n_q, x_q, y_q;
   logic [1:0] fil_q;
   logic       t_q;
   logic       err_q;
   logic       can_issue, cnt_zero;
   logic       cmd_acc, addr_acc, last_addr;

   assign cmd_acc   = cmd_valid && cmd_ready;
   assign addr_acc  = addr_valid && addr_ready;
   assign last_addr = (x_q == n_q - 6'd1) && (y_q == n_q - 6'd1) && t_q;

   ifmap_credit_cnt #(.MAX_OUT(MAX_OUT)) u_credit (
      .clk       (clk),
      .rst_n     (rst_n),
      .inc       (addr_acc),
      .dec       (rdata_ret),
      .can_issue (can_issue),
      .is_zero   (cnt_zero)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state_q <= IDLE;
      else        state_q <= state_d;
   end

   always_comb begin
      state_d    = state_q;
      cmd_ready  = 1'b0;
      addr_valid = 1'b0;
      busy       = 1'b1;
      done       = 1'b0;
      case (state_q)
         IDLE: begin
            cmd_ready = 1'b1;
            busy      = 1'b0;
            // Illegal filter code is swallowed here; err is flagged a cycle later.
            if (cmd_valid && (cmd_fil_size != FIL_BAD)) begin
               state_d = (cmd_conv_size == 6'd0) ? DONE : ISSUE;
            end
         end
         ISSUE: begin
            addr_valid = can_issue;
            if (can_issue && addr_ready && last_addr) state_d = DRAIN;
         end
         DRAIN: begin
            if (cnt_zero) state_d = DONE;
         end
         DONE: begin
            done    = 1'b1;
            state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         n_q   <= 6'd0;
         fil_q <= 2'b00;
         x_q   <= 6'd0;
         y_q   <= 6'd0;
         t_q   <= 1'b0;
         err_q <= 1'b0;
      end else begin
         err_q <= cmd_acc && (cmd_fil_size == FIL_BAD);
         if (cmd_acc) begin
            n_q   <= cmd_conv_size;
            fil_q <= cmd_fil_size;
            x_q   <= 6'd0;
            y_q   <= 6'd0;
            t_q   <= 1'b0;
         end else if (addr_acc) begin
            t_q <= ~t_q;
            if (t_q) begin
               if (y_q == n_q - 6'd1) begin
                  y_q <= 6'd0;
                  x_q <= x_q + 6'd1;
               end else begin
                  y_q <= y_q + 6'd1;
               end
            end
         end
      end
   end

   assign addr = ADDR_W'(pack_addr(fil_q, x_q, y_q, t_q));
   assign err  = err_q;

endmodule

// File: tb/tb_ifmap_rd_addr_gen.sv
// Scoreboard bench for ifmap_rd_addr_gen: expected addresses are queued per
// command and popped as the DUT hands addresses over.
module tb_ifmap_rd_addr_gen;

   localparam int MAX_OUT = 4;
   localparam int ADDR_W  = 15;

   logic              clk = 1'b0;
   logic              rst_n = 1'b1;
   logic              cmd_valid = 1'b0;
   logic              cmd_ready;
   logic [5:0]        cmd_conv_size = '0;
   logic [1:0]        cmd_fil_size = '0;
   logic              addr_valid;
   logic              addr_ready = 1'b0;
   logic [ADDR_W-1:0] addr;
   logic              rdata_ret;
   logic              man_ret = 1'b0;
   logic              auto_ret = 1'b0;
   logic              busy, done, err;

   assign rdata_ret = man_ret | auto_ret;

   always #5 clk = ~clk;

   ifmap_rd_addr_gen #(.MAX_OUT(MAX_OUT), .ADDR_W(ADDR_W)) dut (
      .clk           (clk),
      .rst_n         (rst_n),
      .cmd_valid     (cmd_valid),
      .cmd_ready     (cmd_ready),
      .cmd_conv_size (cmd_conv_size),
      .cmd_fil_size  (cmd_fil_size),
      .addr_valid    (addr_valid),
      .addr_ready    (addr_ready),
      .addr          (addr),
      .rdata_ret     (rdata_ret),
      .busy          (busy),
      .done          (done),
      .err           (err)
   );

   int total = 0;
   int bad   = 0;
   int n_acc = 0;
   int n_done = 0;
   int n_err = 0;
   int cyc = 0;
   bit resp_en = 1'b0;
   logic [ADDR_W-1:0] exp_q[$];
   int                due_q[$];
   bit                stall_prev = 1'b0;
   logic [ADDR_W-1:0] stall_addr = '0;
   logic [ADDR_W-1:0] mon_exp;

   function automatic logic [ADDR_W-1:0] mk_addr(input int f, input int x, input int y, input int t);
      logic [1:0] ff;
      logic [5:0] xx, yy;
      logic       tt;
      ff = f[1:0];
      xx = x[5:0];
      yy = y[5:0];
      tt = t[0];
      return ADDR_W'({ff, xx, yy, tt});
   endfunction

   task automatic push_layer(input int n, input int f);
      for (int x = 0; x < n; x++)
         for (int y = 0; y < n; y++)
            for (int t = 0; t < 2; t++)
               exp_q.push_back(mk_addr(f, x, y, t));
   endtask

   // Scoreboard monitor: pops on every handshake, checks hold during stalls.
   initial forever begin
      @(negedge clk);
      if (!rst_n) begin
         stall_prev = 1'b0;
      end else begin
         if (stall_prev) begin
            total++;
            if (addr_valid !== 1'b1 || addr !== stall_addr) begin
               bad++;
               $display("FAIL stall_hold: valid=%b addr=%h required valid=1 addr=%h",
                        addr_valid, addr, stall_addr);
            end
         end
         if (addr_valid === 1'b1 && addr_ready === 1'b1) begin
            n_acc++;
            total++;
            if (exp_q.size() == 0) begin
               bad++;
               $display("FAIL addr_unexpected: got %h required no address", addr);
            end else begin
               mon_exp = exp_q.pop_front();
               if (addr !== mon_exp) begin
                  bad++;
                  $display("FAIL addr_order: got %h required %h", addr, mon_exp);
               end
            end
            if (resp_en) due_q.push_back(cyc + 2);
         end
         stall_prev = (addr_valid === 1'b1) && (addr_ready !== 1'b1);
         stall_addr = addr;
         if (done === 1'b1) n_done++;
         if (err === 1'b1) n_err++;
      end
   end

   // Memory model: one return pulse two cycles after each accepted address.
   initial forever begin
      @(posedge clk);
      cyc++;
      #1;
      auto_ret = 1'b0;
      if (due_q.size() > 0 && due_q[0] <= cyc) begin
         void'(due_q.pop_front());
         auto_ret = 1'b1;
      end
   end

   task automatic cycles(input int k);
      repeat (k) @(posedge clk);
      #1;
   endtask

   task automatic send_cmd(input int n, input int f, output bit ok);
      @(posedge clk);
      #1;
      cmd_conv_size = n[5:0];
      cmd_fil_size  = f[1:0];
      cmd_valid     = 1'b1;
      ok = 1'b0;
      for (int i = 0; i < 50; i++) begin
         @(negedge clk);
         if (cmd_ready === 1'b1) begin
            ok = 1'b1;
            break;
         end
      end
      @(posedge clk);
      #1;
      cmd_valid = 1'b0;
   endtask

   task automatic wait_done(input int bound, output bit ok);
      ok = 1'b0;
      for (int i = 0; i < bound; i++) begin
         @(negedge clk);
         if (done === 1'b1) begin
            ok = 1'b1;
            break;
         end
      end
   endtask

   task automatic test_reset;
      #1 rst_n = 1'b0;
      #2;
      total++; if (addr_valid !== 1'b0) begin bad++; $display("FAIL rst_addr_valid: got %b required 0", addr_valid); end
      total++; if (addr !== '0) begin bad++; $display("FAIL rst_addr: got %h required 0", addr); end
      total++; if (busy !== 1'b0) begin bad++; $display("FAIL rst_busy: got %b required 0", busy); end
      total++; if (done !== 1'b0) begin bad++; $display("FAIL rst_done: got %b required 0", done); end
      total++; if (err !== 1'b0) begin bad++; $display("FAIL rst_err: got %b required 0", err); end
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk);
      #1;
      total++; if (cmd_ready !== 1'b1) begin bad++; $display("FAIL rst_cmd_ready: got %b required 1", cmd_ready); end
   endtask

   task automatic test_basic;
      bit ok, seen;
      int base, d0, first, last;
      resp_en = 1'b1;
      addr_ready = 1'b1;
      base = n_acc; d0 = n_done; first = -1; last = -1; seen = 1'b0;
      push_layer(2, 0);
      send_cmd(2, 0, ok);
      total++; if (!ok) begin bad++; $display("FAIL basic_cmd_accept: got 0 required 1"); end
      for (int i = 0; i < 100; i++) begin
         @(negedge clk);
         if (addr_valid === 1'b1 && addr_ready === 1'b1) begin
            if (first < 0) first = cyc;
            last = cyc;
         end
         if (done === 1'b1) begin seen = 1'b1; break; end
      end
      total++; if (!seen) begin bad++; $display("FAIL basic_done: got timeout required done"); end
      total++; if (n_acc - base != 8) begin bad++; $display("FAIL basic_count: got %0d required 8", n_acc - base); end
      total++; if (exp_q.size() != 0) begin bad++; $display("FAIL basic_left: got %0d required 0", exp_q.size()); end
      total++; if (last - first != 7) begin bad++; $display("FAIL basic_rate: got span %0d required 7", last - first); end
      cycles(3);
      total++; if (n_done - d0 != 1) begin bad++; $display("FAIL basic_done_once: got %0d required 1", n_done - d0); end
   endtask

   task automatic test_credit;
      bit ok;
      int base;
      resp_en = 1'b0;
      addr_ready = 1'b1;
      base = n_acc;
      push_layer(3, 0);
      send_cmd(3, 0, ok);
      cycles(15);
      total++; if (n_acc - base != 4) begin bad++; $display("FAIL credit_limit: got %0d required 4", n_acc - base); end
      total++; if (addr_valid !== 1'b0) begin bad++; $display("FAIL credit_valid_low: got %b required 0", addr_valid); end
      man_ret = 1'b1; cycles(1); man_ret = 1'b0;
      cycles(8);
      total++; if (n_acc - base != 5) begin bad++; $display("FAIL credit_one_more: got %0d required 5", n_acc - base); end
      total++; if (addr_valid !== 1'b0) begin bad++; $display("FAIL credit_refill_low: got %b required 0", addr_valid); end
      // Returns held high: first edge frees a credit, next five pair accept with return.
      man_ret = 1'b1; cycles(6); man_ret = 1'b0;
      cycles(8);
      total++; if (n_acc - base != 11) begin bad++; $display("FAIL credit_same_cycle: got %0d required 11", n_acc - base); end
      total++; if (addr_valid !== 1'b0) begin bad++; $display("FAIL credit_same_low: got %b required 0", addr_valid); end
      man_ret = 1'b1;
      wait_done(200, ok);
      man_ret = 1'b0;
      total++; if (!ok) begin bad++; $display("FAIL credit_done: got timeout required done"); end
      total++; if (n_acc - base != 18) begin bad++; $display("FAIL credit_total: got %0d required 18", n_acc - base); end
      total++; if (exp_q.size() != 0) begin bad++; $display("FAIL credit_left: got %0d required 0", exp_q.size()); end
      // Stray returns while idle must not disturb the empty counter.
      cycles(1);
      man_ret = 1'b1; cycles(3); man_ret = 1'b0;
      base = n_acc;
      push_layer(3, 1);
      send_cmd(3, 1, ok);
      cycles(15);
      total++; if (n_acc - base != 4) begin bad++; $display("FAIL credit_zero_ret: got %0d required 4", n_acc - base); end
      man_ret = 1'b1;
      wait_done(200, ok);
      man_ret = 1'b0;
      total++; if (!ok || exp_q.size() != 0) begin bad++; $display("FAIL credit_zero_drain: got done=%0d left=%0d required done=1 left=0", ok, exp_q.size()); end
   endtask

   task automatic test_stall;
      bit ok;
      int base;
      logic [ADDR_W-1:0] want;
      resp_en = 1'b1;
      addr_ready = 1'b1;
      base = n_acc;
      push_layer(2, 2);
      send_cmd(2, 2, ok);
      for (int i = 0; i < 50; i++) begin
         @(posedge clk);
         #1;
         if (n_acc - base >= 3) break;
      end
      addr_ready = 1'b0;
      want = mk_addr(2, 0, 1, 1);
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         total++;
         if (addr_valid !== 1'b1 || addr !== want) begin
            bad++;
            $display("FAIL stall_cycle%0d: valid=%b addr=%h required valid=1 addr=%h", i, addr_valid, addr, want);
         end
      end
      @(posedge clk);
      #1;
      addr_ready = 1'b1;
      wait_done(100, ok);
      total++; if (!ok) begin bad++; $display("FAIL stall_done: got timeout required done"); end
      total++; if (n_acc - base != 8 || exp_q.size() != 0) begin bad++; $display("FAIL stall_total: got %0d left=%0d required 8 left=0", n_acc - base, exp_q.size()); end
   endtask

   task automatic test_illegal;
      bit ok;
      int base, e0, d0;
      base = n_acc; e0 = n_err; d0 = n_done;
      send_cmd(2, 3, ok);
      @(negedge clk);
      total++; if (err !== 1'b1) begin bad++; $display("FAIL illegal_err: got %b required 1", err); end
      total++; if (cmd_ready !== 1'b1 || busy !== 1'b0) begin bad++; $display("FAIL illegal_idle: ready=%b busy=%b required 1 0", cmd_ready, busy); end
      @(negedge clk);
      total++; if (err !== 1'b0) begin bad++; $display("FAIL illegal_err_pulse: got %b required 0", err); end
      cycles(4);
      total++; if (n_acc != base || n_err - e0 != 1) begin bad++; $display("FAIL illegal_counts: acc=%0d err=%0d required 0 1", n_acc - base, n_err - e0); end
      send_cmd(0, 1, ok);
      @(negedge clk);
      total++; if (done !== 1'b1 || addr_valid !== 1'b0) begin bad++; $display("FAIL zero_done: done=%b valid=%b required 1 0", done, addr_valid); end
      @(negedge clk);
      total++; if (done !== 1'b0 || cmd_ready !== 1'b1) begin bad++; $display("FAIL zero_after: done=%b ready=%b required 0 1", done, cmd_ready); end
      total++; if (n_acc != base || n_done - d0 != 1) begin bad++; $display("FAIL zero_counts: acc=%0d done=%0d required 0 1", n_acc - base, n_done - d0); end
   endtask

   task automatic test_reset_mid;
      bit ok;
      int base, d0;
      resp_en = 1'b1;
      addr_ready = 1'b1;
      base = n_acc; d0 = n_done;
      push_layer(3, 0);
      send_cmd(3, 0, ok);
      for (int i = 0; i < 50; i++) begin
         @(posedge clk);
         #1;
         if (n_acc - base >= 3) break;
      end
      #2 rst_n = 1'b0;
      #1;
      total++; if (addr !== '0 || addr_valid !== 1'b0) begin bad++; $display("FAIL midrst_addr: addr=%h valid=%b required 0 0", addr, addr_valid); end
      total++; if (busy !== 1'b0 || done !== 1'b0 || err !== 1'b0) begin bad++; $display("FAIL midrst_ctl: busy=%b done=%b err=%b required 0 0 0", busy, done, err); end
      total++; if (n_acc - base != 3) begin bad++; $display("FAIL midrst_count: got %0d required 3", n_acc - base); end
      exp_q.delete();
      #10 rst_n = 1'b1;
      cycles(3);
      total++; if (n_done != d0) begin bad++; $display("FAIL midrst_no_done: got %0d required 0", n_done - d0); end
      base = n_acc;
      push_layer(3, 0);
      send_cmd(3, 0, ok);
      wait_done(300, ok);
      total++; if (!ok) begin bad++; $display("FAIL midrst_done: got timeout required done"); end
      total++; if (n_acc - base != 18 || exp_q.size() != 0) begin bad++; $display("FAIL midrst_total: got %0d left=%0d required 18 left=0", n_acc - base, exp_q.size()); end
   endtask

   task automatic test_back_to_back;
      bit ok;
      int base;
      resp_en = 1'b1;
      addr_ready = 1'b1;
      base = n_acc;
      push_layer(1, 0);
      push_layer(2, 2);
      send_cmd(1, 0, ok);
      wait_done(100, ok);
      total++; if (!ok) begin bad++; $display("FAIL b2b_first_done: got timeout required done"); end
      cmd_conv_size = 6'd2;
      cmd_fil_size  = 2'd2;
      cmd_valid     = 1'b1;
      @(posedge clk);
      #1;
      total++; if (cmd_ready !== 1'b1 || busy !== 1'b0) begin bad++; $display("FAIL b2b_ready: ready=%b busy=%b required 1 0", cmd_ready, busy); end
      @(posedge clk);
      #1;
      cmd_valid = 1'b0;
      total++; if (busy !== 1'b1) begin bad++; $display("FAIL b2b_accept: busy=%b required 1", busy); end
      wait_done(100, ok);
      total++; if (!ok || n_acc - base != 10 || exp_q.size() != 0) begin bad++; $display("FAIL b2b_total: done=%0d acc=%0d left=%0d required 1 10 0", ok, n_acc - base, exp_q.size()); end
   endtask

   initial begin
      test_reset();
      test_basic();
      test_credit();
      test_stall();
      test_illegal();
      test_reset_mid();
      test_back_to_back();
      cycles(3);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
